// File: rtl/bru_pkg.sv
// bru_pkg: shared constants for the branch resolve / predict unit.
// Holds the bru_op one-hot bit positions, 2-bit counter encodings,
// default parameter values and the saturating counter step function.
package bru_pkg;

   // Default parameter values
   localparam int XLEN_DEF      = 64;
   localparam int ADDR_W_DEF    = 32;
   localparam int BHT_DEPTH_DEF = 64;

   // bru_op bit positions, one-hot {jal,jalr,beq,bne,blt,bge,bltu,bgeu} MSB first
   localparam int OP_JAL  = 7;
   localparam int OP_JALR = 6;
   localparam int OP_BEQ  = 5;
   localparam int OP_BNE  = 4;
   localparam int OP_BLT  = 3;
   localparam int OP_BGE  = 2;
   localparam int OP_BLTU = 1;
   localparam int OP_BGEU = 0;

   // Conditional branches: everything except jal/jalr
   localparam logic [7:0] OP_COND_MASK = 8'h3F;

   // 2-bit branch history counter encodings; MSB is the taken prediction
   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } cnt_e;

   // Saturating step: move toward ST on taken, toward SNT on not-taken
   function automatic cnt_e cnt_next(input cnt_e c, input logic taken);
      case (c)
         CNT_SNT: return taken ? CNT_WNT : CNT_SNT;
         CNT_WNT: return taken ? CNT_WT  : CNT_SNT;
         CNT_WT:  return taken ? CNT_ST  : CNT_WNT;
         default: return taken ? CNT_ST  : CNT_WT;
      endcase
   endfunction

endpackage

// File: rtl/bru_bht.sv
// bru_bht: table of 2-bit saturating branch history counters.
// Latency: combinational read, write lands at the next clk edge (read-before-write).
// Backpressure: none; a write is applied whenever wr_en is high.
//
// Ports:
//   clk, rst          clock, async active-high reset (all counters -> WNT)
//   rd_idx, rd_taken  read port: MSB of counter at rd_idx
//   wr_en, wr_idx,    write port: saturating step of counter at wr_idx
//   wr_taken            toward taken (1) or not-taken (0)
module bru_bht
   import bru_pkg::*;
#(
   parameter int DEPTH = BHT_DEPTH_DEF,
   localparam int IDX_W = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   logic [1:0] tbl [DEPTH];

   // Read sees the table contents before any same-cycle write lands
   assign rd_taken = tbl[rd_idx][1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl[i] <= CNT_WNT;
         end
      end else if (wr_en) begin
         tbl[wr_idx] <= cnt_next(cnt_e'(tbl[wr_idx]), wr_taken);
      end
   end

endmodule

// File: rtl/bru_pred.sv
// bru_pred: branch resolve unit with a 2-bit-counter branch history table.
// Latency: 1 cycle from accepted request to registered result.
// Backpressure: in_ready = ~out_valid | out_ready; the result holds while out_valid & ~out_ready.
//
// Optional feature macro: BRU_PERF_CNT_EN adds perf_br_cnt / perf_mis_cnt.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   in_valid/in_ready                 request handshake
//   pc, bru_op, rdata1, rdata2, imm   branch to resolve (bru_op one-hot, jal MSB)
//   pred_taken, pred_addr             what fetch predicted
//   flush                             drop the registered result (beats an accept)
//   lookup_pc/lookup_taken            fetch-side BHT query, combinational
//   out_valid/out_ready               result handshake
//   br_e, br_addr, br_result          taken, target, pc+4 (ADDR_W bits, zero-extended)
//   mispredict, redirect_addr         redirect request and correct next PC
//   perf_br_cnt, perf_mis_cnt         saturating completion counters (macro only)
module bru_pred
   import bru_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int BHT_DEPTH = BHT_DEPTH_DEF
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc,
   input  logic [7:0]      bru_op,
   input  logic [XLEN-1:0] rdata1,
   input  logic [XLEN-1:0] rdata2,
   input  logic [XLEN-1:0] imm,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_addr,
   input  logic            flush,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            lookup_taken,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            br_e,
   output logic [XLEN-1:0] br_addr,
   output logic [XLEN-1:0] br_result,
   output logic            mispredict,
`ifdef BRU_PERF_CNT_EN
   output logic [31:0]     perf_br_cnt,
   output logic [31:0]     perf_mis_cnt,
`endif
   output logic [XLEN-1:0] redirect_addr
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic              accept;
   logic              is_cond;
   logic              eq;
   logic              lt;
   logic              ltu;
   logic              taken;
   logic              mis_c;
   logic [ADDR_W-1:0] pc_imm;
   logic [ADDR_W-1:0] rs1_imm;
   logic [ADDR_W-1:0] pc_plus4;
   logic [XLEN-1:0]   tgt_c;
   logic [XLEN-1:0]   res_c;
   logic [XLEN-1:0]   redir_c;
   logic              unused_ok;

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   assign is_cond  = |(bru_op & OP_COND_MASK);

   // Compares are over the full operand width
   assign eq  = (rdata1 == rdata2);
   assign lt  = ($signed(rdata1) < $signed(rdata2));
   assign ltu = (rdata1 < rdata2);

   // Address arithmetic is done at ADDR_W so it wraps naturally
   assign pc_imm   = pc[ADDR_W-1:0] + imm[ADDR_W-1:0];
   assign rs1_imm  = rdata1[ADDR_W-1:0] + imm[ADDR_W-1:0];
   assign pc_plus4 = pc[ADDR_W-1:0] + ADDR_W'(4);

   // Bits only partly consumed by the narrow address math / BHT indexing
   assign unused_ok = ^{pc, imm, lookup_pc, rs1_imm[0]};

   always_comb begin
      taken = bru_op[OP_JAL]  | bru_op[OP_JALR]
            | (bru_op[OP_BEQ]  &  eq)
            | (bru_op[OP_BNE]  & ~eq)
            | (bru_op[OP_BLT]  &  lt)
            | (bru_op[OP_BGE]  & ~lt)
            | (bru_op[OP_BLTU] &  ltu)
            | (bru_op[OP_BGEU] & ~ltu);

      tgt_c = '0;
      res_c = '0;
      res_c[ADDR_W-1:0] = pc_plus4;
      if (bru_op[OP_JALR]) begin
         tgt_c[ADDR_W-1:0] = {rs1_imm[ADDR_W-1:1], 1'b0};
      end else if (|bru_op) begin
         tgt_c[ADDR_W-1:0] = pc_imm;
      end

      // With no op selected taken=0, so this reduces to pred_taken
      mis_c   = (taken != pred_taken) | (taken & (pred_addr != tgt_c));
      redir_c = taken ? tgt_c : res_c;
   end

   // Result register: flush wins over an accept in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         br_e          <= 1'b0;
         br_addr       <= '0;
         br_result     <= '0;
         mispredict    <= 1'b0;
         redirect_addr <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         br_e          <= taken;
         br_addr       <= tgt_c;
         br_result     <= res_c;
         mispredict    <= mis_c;
         redirect_addr <= redir_c;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Only conditional branches train the table; a flushed accept does not
   bru_bht #(
      .DEPTH (BHT_DEPTH)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (lookup_pc[IDX_W+1:2]),
      .rd_taken (lookup_taken),
      .wr_en    (accept & is_cond & ~flush),
      .wr_idx   (pc[IDX_W+1:2]),
      .wr_taken (taken)
   );

`ifdef BRU_PERF_CNT_EN
   logic out_cond;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_cond <= 1'b0;
      end else if (accept & ~flush) begin
         out_cond <= is_cond;
      end
   end

   // Counted at completion, saturating at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_br_cnt  <= '0;
         perf_mis_cnt <= '0;
      end else if (out_valid & out_ready) begin
         if (out_cond && (perf_br_cnt != '1)) begin
            perf_br_cnt <= perf_br_cnt + 32'd1;
         end
         if (mispredict && (perf_mis_cnt != '1)) begin
            perf_mis_cnt <= perf_mis_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bru_pred.sv
// tb_bru_pred: directed scenarios plus randomized traffic checked against a
// behavioural model (branch rules in plain arithmetic, counters as ints).
module tb_bru_pred;

   localparam int XLEN   = 64;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 64;
   localparam logic [63:0] AMASK = 64'h0000_0000_FFFF_FFFF;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] pc;
   logic [7:0]      bru_op;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic [XLEN-1:0] imm;
   logic            pred_taken;
   logic [XLEN-1:0] pred_addr;
   logic            flush;
   logic [XLEN-1:0] lookup_pc;
   logic            lookup_taken;
   logic            out_valid;
   logic            out_ready;
   logic            br_e;
   logic [XLEN-1:0] br_addr;
   logic [XLEN-1:0] br_result;
   logic            mispredict;
   logic [XLEN-1:0] redirect_addr;

   always #5 clk = ~clk;

   bru_pred #(.XLEN(XLEN), .ADDR_W(ADDR_W), .BHT_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pc(pc), .bru_op(bru_op), .rdata1(rdata1), .rdata2(rdata2), .imm(imm),
      .pred_taken(pred_taken), .pred_addr(pred_addr), .flush(flush),
      .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
      .out_valid(out_valid), .out_ready(out_ready), .br_e(br_e),
      .br_addr(br_addr), .br_result(br_result), .mispredict(mispredict),
      .redirect_addr(redirect_addr)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state
   int          cnt [DEPTH];
   logic        m_vld;
   logic        m_e;
   logic        m_mis;
   logic [63:0] m_addr;
   logic [63:0] m_res;
   logic [63:0] m_redir;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int bidx(input logic [63:0] p);
      return int'((p >> 2) % 64'(DEPTH));
   endfunction

   function automatic logic op_is_cond(input logic [7:0] op);
      return op inside {8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
   endfunction

   // Branch rules straight from the definition of each opcode
   task automatic resolve(input logic [7:0] op, input logic [63:0] p, a, b, im,
                          input logic pt, input logic [63:0] pa,
                          output logic e, output logic [63:0] addr, res, redir,
                          output logic mis);
      longint sa, sb;
      sa = a;
      sb = b;
      e = 1'b0;
      addr = 64'h0;
      case (op)
         8'h80: e = 1'b1;
         8'h40: e = 1'b1;
         8'h20: e = (a == b);
         8'h10: e = (a != b);
         8'h08: e = (sa < sb);
         8'h04: e = (sa >= sb);
         8'h02: e = (a < b);
         8'h01: e = (a >= b);
         default: e = 1'b0;
      endcase
      if (op == 8'h40) addr = ((a + im) & AMASK) & ~64'h1;
      else if (op != 8'h00) addr = (p + im) & AMASK;
      res   = (p + 64'd4) & AMASK;
      redir = e ? addr : res;
      mis   = (e != pt) || (e && (pa != addr));
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) cnt[i] = 1;
      m_vld = 1'b0;
   endtask

   task automatic set_req(input logic [7:0] op, input logic [63:0] p, a, b, im,
                          input logic pt, input logic [63:0] pa);
      in_valid = 1'b1; bru_op = op; pc = p; rdata1 = a; rdata2 = b; imm = im;
      pred_taken = pt; pred_addr = pa;
   endtask

   // One clock: check combinational outputs, step the model at the edge,
   // then check the registered outputs just after it.
   task automatic cycle(input string tag);
      logic e, mis, acc;
      logic [63:0] a, r, rd;
      int k;
      #1;
      check({tag, ":in_ready"}, 64'(in_ready), 64'(!m_vld || out_ready));
      check({tag, ":lookup"}, 64'(lookup_taken), 64'(cnt[bidx(lookup_pc)] >= 2));
      acc = in_valid && (!m_vld || out_ready);
      resolve(bru_op, pc, rdata1, rdata2, imm, pred_taken, pred_addr, e, a, r, rd, mis);
      @(posedge clk);
      if (acc && !flush && op_is_cond(bru_op)) begin
         k = bidx(pc);
         if (e) cnt[k] = (cnt[k] == 3) ? 3 : cnt[k] + 1;
         else   cnt[k] = (cnt[k] == 0) ? 0 : cnt[k] - 1;
      end
      if (flush) m_vld = 1'b0;
      else if (acc) begin
         m_vld = 1'b1; m_e = e; m_addr = a; m_res = r; m_redir = rd; m_mis = mis;
      end else if (out_ready) m_vld = 1'b0;
      #1;
      check({tag, ":out_valid"}, 64'(out_valid), 64'(m_vld));
      if (m_vld) begin
         check({tag, ":br_e"}, 64'(br_e), 64'(m_e));
         check({tag, ":br_addr"}, br_addr, m_addr);
         check({tag, ":br_result"}, br_result, m_res);
         check({tag, ":mispredict"}, 64'(mispredict), 64'(m_mis));
         check({tag, ":redirect"}, redirect_addr, m_redir);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; bru_op = 8'h00; pc = '0; rdata1 = '0; rdata2 = '0;
      imm = '0; pred_taken = 1'b0; pred_addr = '0; flush = 1'b0; lookup_pc = 64'h40;
      out_ready = 1'b1;
      model_reset();

      // Reset state
      @(posedge clk); #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_br_e", 64'(br_e), 64'd0);
      check("rst_mispredict", 64'(mispredict), 64'd0);
      check("rst_br_addr", br_addr, 64'd0);
      check("rst_br_result", br_result, 64'd0);
      check("rst_redirect", redirect_addr, 64'd0);
      check("rst_lookup", 64'(lookup_taken), 64'd0);
      rst = 1'b0;

      // beq taken, predicted not-taken
      set_req(8'h20, 64'h1000, 64'd5, 64'd5, 64'h20, 1'b0, 64'h0);
      cycle("s023");
      check("s023_br_e", 64'(br_e), 64'd1);
      check("s023_br_addr", br_addr, 64'h1020);
      check("s023_mis", 64'(mispredict), 64'd1);
      check("s023_redir", redirect_addr, 64'h1020);

      // signed vs unsigned less-than
      set_req(8'h08, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 1'b0, 64'h0);
      cycle("s024_blt");
      check("s024_blt_br_e", 64'(br_e), 64'd1);
      set_req(8'h02, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 1'b0, 64'h0);
      cycle("s024_bltu");
      check("s024_bltu_br_e", 64'(br_e), 64'd0);
      check("s024_bltu_res", br_result, 64'h2004);

      // jalr clears bit 0, correctly predicted
      set_req(8'h40, 64'h3000, 64'h2001, 64'h0, 64'h4, 1'b1, 64'h2004);
      cycle("s025");
      check("s025_br_addr", br_addr, 64'h2004);
      check("s025_mis", 64'(mispredict), 64'd0);

      // jal across the 2^32 boundary wraps
      set_req(8'h80, 64'hFFFF_FFFC, 64'h0, 64'h0, 64'h8, 1'b1, 64'h4);
      cycle("wrap");
      check("wrap_br_addr", br_addr, 64'h4);
      check("wrap_br_result", br_result, 64'h0);
      check("wrap_mis", 64'(mispredict), 64'd0);

      // no op selected, predicted taken
      set_req(8'h00, 64'h5000, 64'h1, 64'h2, 64'h8, 1'b1, 64'h5008);
      cycle("noop");
      check("noop_br_e", 64'(br_e), 64'd0);
      check("noop_br_addr", br_addr, 64'h0);
      check("noop_mis", 64'(mispredict), 64'd1);
      check("noop_redir", redirect_addr, 64'h5004);

      // Counter training at pc 0x40: 01 -> 10 -> 11 -> 11 -> 10 -> 01
      lookup_pc = 64'h40;
      #1 check("s026_init", 64'(lookup_taken), 64'd0);
      set_req(8'h10, 64'h40, 64'd1, 64'd2, 64'h8, 1'b0, 64'h0);
      cycle("s026_t1");
      check("s026_after_t1", 64'(lookup_taken), 64'd1);
      cycle("s026_t2");
      cycle("s026_t3");
      check("s026_after_t3", 64'(lookup_taken), 64'd1);
      set_req(8'h10, 64'h40, 64'd3, 64'd3, 64'h8, 1'b0, 64'h0);
      cycle("s026_n1");
      check("s026_after_n1", 64'(lookup_taken), 64'd1);
      cycle("s026_n2");
      check("s026_after_n2", 64'(lookup_taken), 64'd0);

      // Hold under backpressure, then flush during the hold
      set_req(8'h80, 64'h6000, 64'h0, 64'h0, 64'h100, 1'b0, 64'h0);
      out_ready = 1'b1;
      cycle("s027_load");
      out_ready = 1'b0;
      set_req(8'h20, 64'h7000, 64'd9, 64'd9, 64'h40, 1'b0, 64'h0);
      cycle("s027_h1");
      check("s027_h1_in_ready", 64'(in_ready), 64'd0);
      check("s027_h1_br_addr", br_addr, 64'h6100);
      flush = 1'b1;
      cycle("s027_h2");
      check("s027_flush_vld", 64'(out_valid), 64'd0);
      flush = 1'b0;
      cycle("s027_h3");
      out_ready = 1'b1; in_valid = 1'b0;
      cycle("drain");

      // Flush beats a same-cycle accept and suppresses training
      lookup_pc = 64'h80;
      set_req(8'h10, 64'h80, 64'd1, 64'd2, 64'h8, 1'b0, 64'h0);
      flush = 1'b1;
      cycle("flush_acc");
      check("flush_acc_vld", 64'(out_valid), 64'd0);
      check("flush_acc_bht", 64'(lookup_taken), 64'd0);
      flush = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [7:0] op;
         logic [63:0] a, b, p, im, tg, r0, rd0;
         logic signed [11:0] s12;
         logic e0, m0;
         int k;
         k = $urandom_range(0, 8);
         op = (k == 8) ? 8'h00 : (8'h80 >> k);
         a = {$urandom, $urandom};
         b = ($urandom_range(0, 2) == 0) ? a : {$urandom, $urandom};
         p = {32'($urandom_range(0, 3)), $urandom} & ~64'h3;
         s12 = 12'($urandom);
         im = 64'(s12);
         resolve(op, p, a, b, im, 1'b0, 64'h0, e0, tg, r0, rd0, m0);
         set_req(op, p, a, b, im, 1'($urandom), ($urandom_range(0, 1) == 1) ? tg : {$urandom, $urandom});
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         lookup_pc = ($urandom_range(0, 1) == 1) ? p : 64'($urandom);
         cycle("rnd");
      end
      flush = 1'b0;

      // Reset while a result is held: drive 0x40 to strongly taken first
      out_ready = 1'b1;
      lookup_pc = 64'h40;
      set_req(8'h10, 64'h40, 64'd1, 64'd2, 64'h8, 1'b0, 64'h0);
      cycle("s028_t1");
      cycle("s028_t2");
      cycle("s028_t3");
      check("s028_pre_lookup", 64'(lookup_taken), 64'd1);
      out_ready = 1'b0;
      cycle("s028_hold");
      rst = 1'b1;
      model_reset();
      #1;
      check("s028_vld", 64'(out_valid), 64'd0);
      check("s028_br_e", 64'(br_e), 64'd0);
      check("s028_br_addr", br_addr, 64'd0);
      check("s028_mis", 64'(mispredict), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         lookup_pc = 64'(i * 4);
         #1 check("s028_lookup", 64'(lookup_taken), 64'd0);
      end

      // Normal operation after reset
      set_req(8'h01, 64'h9000, 64'd7, 64'd3, 64'h30, 1'b1, 64'h9030);
      cycle("post_rst");
      check("post_rst_br_e", 64'(br_e), 64'd1);
      check("post_rst_mis", 64'(mispredict), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
